demux5_dispatcher: RTL and testbench

DEMUX5_DISPATCHER -- requirements
Module: demux5_dispatcher

---
 rtl/demux5_dispatcher.sv | 120 ++++++++++++
 tb/tb_demux5_dispatcher.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/demux5_dispatcher.sv
// demux5_dispatcher: one-word buffered dispatcher feeding a 1:5 demux.
// A word is captured in IDLE. SEARCH picks a ready destination round-robin
// from ptr. SEND offers the word until that destination takes it.
// The burst counter rotates the pointer after MAX_BURST consecutive
// transfers to the same destination.
// Optional macro DEMUX5_DISPATCHER_MASK_EN adds the dst_enable eligibility mask.
module demux5_dispatcher #(
   parameter int unsigned WIDTH     = 1,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       dst_ready,
`ifdef DEMUX5_DISPATCHER_MASK_EN
   input  logic [4:0]       dst_enable,
`endif
   output logic [WIDTH-1:0] out_data,
   output logic [2:0]       sel,
   output logic [4:0]       out_valid
);

   typedef enum logic [1:0] {IDLE, SEARCH, SEND} state_t;

   localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

   state_t           state_q;
   logic [WIDTH-1:0] data_q;
   logic [2:0]       ptr_q;
   logic [3:0]       cnt_q;
   logic [2:0]       sel_q;
   logic [2:0]       last_q;
   logic [4:0]       out_valid_q;

   logic [4:0] elig;
   logic       hit_d;
   logic [2:0] sel_d;
   logic       xfer;
   logic [3:0] cnt_d;
   logic [3:0] idx;

`ifdef DEMUX5_DISPATCHER_MASK_EN
   assign elig = dst_ready & dst_enable;
`else
   assign elig = dst_ready;
`endif

   // out_valid_q is one-hot on sel_q during SEND, so this is dst_ready[sel_q]
   assign xfer  = (state_q == SEND) && |(dst_ready & out_valid_q);
   assign cnt_d = (sel_q != last_q) ? 4'd1 : cnt_q + 4'd1;

   // Round-robin scan: first eligible destination starting at ptr, modulo 5
   always_comb begin
      hit_d = 1'b0;
      sel_d = '0;
      idx   = '0;
      for (int unsigned k = 0; k < 5; k++) begin
         idx = {1'b0, ptr_q} + 4'(k);
         if (idx >= 4'd5) idx = idx - 4'd5;
         if (!hit_d && elig[idx[2:0]]) begin
            hit_d = 1'b1;
            sel_d = idx[2:0];
         end
      end
   end

   // Dispatcher FSM with registered select, valid vector, pointer and burst count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         data_q      <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         sel_q       <= '0;
         last_q      <= '0;
         out_valid_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  data_q  <= in_data;
                  state_q <= SEARCH;
               end
            end
            SEARCH: begin
               if (hit_d) begin
                  sel_q       <= sel_d;
                  out_valid_q <= 5'b00001 << sel_d;
                  state_q     <= SEND;
               end
            end
            SEND: begin
               if (xfer) begin
                  out_valid_q <= '0;
                  state_q     <= IDLE;
                  last_q      <= sel_q;
                  if (cnt_d == BURST_MAX) begin
                     ptr_q <= (sel_q == 3'd4) ? 3'd0 : sel_q + 3'd1;
                     cnt_q <= '0;
                  end else begin
                     ptr_q <= sel_q;
                     cnt_q <= cnt_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // in_ready is combinational on rst_n so it drops during reset and rises
   // in the very first IDLE cycle after release
   assign in_ready  = rst_n && (state_q == IDLE);
   assign out_data  = data_q;
   assign sel       = sel_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_demux5_dispatcher.sv
// Testbench for demux5_dispatcher: instance A uses MAX_BURST=4 and instance B
// uses MAX_BURST=1. Expected (destination, data) pairs are queued when a word
// is driven. They are popped and compared when a transfer is observed.
module tb_demux5_dispatcher;

   typedef struct {
      logic [2:0] dest;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid_a, in_valid_b;
   logic       rdy_a, rdy_b;
   logic [4:0] dst_ready;
   logic [4:0] dst_en;
   logic [7:0] out_a, out_b;
   logic [2:0] sel_a, sel_b;
   logic [4:0] ov_a, ov_b;

   exp_t qa[$];
   exp_t qb[$];
   int   total = 0;
   int   bad   = 0;
   int   w;

   always #5 clk = ~clk;

   demux5_dispatcher #(.WIDTH(8), .MAX_BURST(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid_a),
      .in_ready(rdy_a), .dst_ready(dst_ready),
`ifdef DEMUX5_DISPATCHER_MASK_EN
      .dst_enable(dst_en),
`endif
      .out_data(out_a), .sel(sel_a), .out_valid(ov_a)
   );

   demux5_dispatcher #(.WIDTH(8), .MAX_BURST(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid_b),
      .in_ready(rdy_b), .dst_ready(dst_ready),
`ifdef DEMUX5_DISPATCHER_MASK_EN
      .dst_enable(dst_en),
`endif
      .out_data(out_b), .sel(sel_b), .out_valid(ov_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Transfer monitor: sampled mid-cycle, the transfer completes on the next rising edge
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (|(ov_a & dst_ready)) begin
            if (qa.size() == 0) chk("a_unexpected_xfer", 32'(ov_a), 32'd0);
            else begin
               exp_t e;
               e = qa.pop_front();
               chk("a_dest", 32'(sel_a), 32'(e.dest));
               chk("a_data", 32'(out_a), 32'(e.data));
               chk("a_onehot", 32'(ov_a), 32'(5'b00001 << e.dest));
            end
         end
         if (|(ov_b & dst_ready)) begin
            if (qb.size() == 0) chk("b_unexpected_xfer", 32'(ov_b), 32'd0);
            else begin
               exp_t e;
               e = qb.pop_front();
               chk("b_dest", 32'(sel_b), 32'(e.dest));
               chk("b_data", 32'(out_b), 32'(e.data));
               chk("b_onehot", 32'(ov_b), 32'(5'b00001 << e.dest));
            end
         end
      end
   end

   // Wait (bounded) for in_ready, offer one word for one cycle, queue its expectation
   task automatic send(input bit on_b, input logic [7:0] d, input logic [2:0] dest,
                       output int waited);
      exp_t e;
      waited = 0;
      while (!(on_b ? rdy_b : rdy_a) && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("ready_reached", 32'(on_b ? rdy_b : rdy_a), 32'd1);
      e.dest  = dest;
      e.data  = d;
      in_data = d;
      if (on_b) begin in_valid_b = 1'b1; qb.push_back(e); end
      else      begin in_valid_a = 1'b1; qa.push_back(e); end
      @(posedge clk); #1;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
   endtask

   // Bounded wait for all queued words of one instance to be delivered
   task automatic drain(input bit on_b);
      int n;
      n = 0;
      while ((on_b ? qb.size() : qa.size()) != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain", 32'(on_b ? qb.size() : qa.size()), 32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      in_data    = '0;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      dst_ready  = 5'b11111;
      dst_en     = 5'b11111;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(rdy_a), 32'd0);
      chk("rst_out_valid", 32'(ov_a), 32'd0);
      chk("rst_sel", 32'(sel_a), 32'd0);
      chk("rst_out_data", 32'(out_a), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("release_in_ready", 32'(rdy_a), 32'd1);

      // MAX_BURST=1: strict rotation 0..4 then wrap to 0
      for (int unsigned i = 0; i < 6; i++)
         send(1'b1, 8'(8'h0A + i), 3'(i % 5), w);
      drain(1'b1);

      // MAX_BURST=4: four words to 0, fifth to 1, one accept every third cycle
      for (int unsigned i = 0; i < 5; i++) begin
         send(1'b0, 8'(8'h01 + i), (i < 4) ? 3'd0 : 3'd1, w);
         if (i > 0) chk("accept_spacing", 32'(w), 32'd2);
      end
      drain(1'b0);

      // three more to dest 1 complete its burst so ptr moves to 2
      for (int unsigned i = 0; i < 3; i++) send(1'b0, 8'(8'h21 + i), 3'd1, w);
      drain(1'b0);

      // ptr=2, only dest 0 ready: scan wraps around to 0
      dst_ready = 5'b00001;
      send(1'b0, 8'h30, 3'd0, w);
      drain(1'b0);
      // ptr=0, dests 0 and 2 ready: 0 wins
      dst_ready = 5'b00101;
      send(1'b0, 8'h31, 3'd0, w);
      drain(1'b0);

      // SEND to 3 is held while dst_ready[3] is low, even with dest 1 ready
      dst_ready = 5'b01000;
      send(1'b0, 8'h33, 3'd3, w);
      @(posedge clk); #1;
      dst_ready = 5'b00010;
      for (int unsigned i = 0; i < 5; i++) begin
         chk("hold_out_valid", 32'(ov_a), 32'h08);
         chk("hold_sel", 32'(sel_a), 32'd3);
         @(posedge clk); #1;
      end
      dst_ready = 5'b01010;
      @(posedge clk); #1;
      chk("held_xfer_done", 32'(qa.size()), 32'd0);
      chk("held_xfer_idle", 32'(ov_a), 32'd0);

      // reset asserted during SEND drops out_valid at once and discards the word
      dst_ready = 5'b00100;
      send(1'b0, 8'h44, 3'd2, w);
      @(posedge clk); #1;
      chk("pre_rst_send", 32'(ov_a), 32'h04);
      dst_ready = 5'b00000;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", 32'(ov_a), 32'd0);
      chk("rst_mid_in_ready", 32'(rdy_a), 32'd0);
      qa.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      dst_ready = 5'b11111;
      #1;
      chk("rst_mid_sel", 32'(sel_a), 32'd0);
      chk("rst_mid_ready", 32'(rdy_a), 32'd1);
      repeat (6) @(posedge clk);
      #1;
      chk("no_ghost_xfer", 32'(ov_a), 32'd0);
      send(1'b0, 8'h55, 3'd0, w);
      drain(1'b0);

`ifdef DEMUX5_DISPATCHER_MASK_EN
      // only dest 4 enabled
      dst_en = 5'b10000;
      send(1'b0, 8'h61, 3'd4, w);
      send(1'b0, 8'h62, 3'd4, w);
      drain(1'b0);
      // empty mask: word accepted but never dispatched
      dst_en = 5'b00000;
      send(1'b0, 8'h63, 3'd0, w);
      qa.delete();
      repeat (10) @(posedge clk);
      #1;
      chk("mask_zero_in_ready", 32'(rdy_a), 32'd0);
      chk("mask_zero_out_valid", 32'(ov_a), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
